// File: rtl/midi_gate_if.sv
// MIDI byte stream into midi_gate: one byte per cycle when in_valid is high.
// There is no back-pressure, so the bus carries no ready signal.
interface midi_gate_if;
    logic       in_valid;
    logic [7:0] in_data;

    modport master (output in_valid, output in_data);
    modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/midi_gate.sv
// MIDI note gate: parses a channel's Note On/Off stream into a last-note-priority stack.
// Optional build macro MIDI_GATE_RETRIGGER_EN: pulse gate low for one cycle on overlapping Note Ons.
module midi_gate #(
    parameter int CHANNEL     = 0,
    parameter int STACK_DEPTH = 4,
    localparam int HELD_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    midi_gate_if.slave        bus,
    output logic              gate,
    output logic [6:0]        note,
    output logic [6:0]        velocity,
    output logic [HELD_W-1:0] held
);
    localparam logic [3:0] CHAN_S = 4'(CHANNEL);

    logic [7:0]        status_r;
    logic              status_valid_r;
    logic              have_d0_r;
    logic [6:0]        d0_r;
    logic [6:0]        stack_r [STACK_DEPTH];

    logic              need_two_s;
    logic              msg_done_s;
    logic [6:0]        key_s;
    logic [6:0]        vel_s;
    logic              ch_match_s;
    logic              note_on_s;
    logic              note_off_s;
    logic              retrig_s;
    logic [6:0]        work_s [STACK_DEPTH];
    logic              found_s;
    int                pos_s;
    int                cnt_s;
    logic [6:0]        top_s;
    logic [HELD_W-1:0] held_next_s;

    // Classify the incoming data byte and detect completion of a message
    always_comb begin
        need_two_s = (status_r[7:5] != 3'b110);
        msg_done_s = 1'b0;
        key_s      = 7'd0;
        vel_s      = 7'd0;
        if (bus.in_valid && !bus.in_data[7] && status_valid_r) begin
            if (need_two_s && !have_d0_r) begin
                msg_done_s = 1'b0;
            end else begin
                msg_done_s = 1'b1;
                key_s      = need_two_s ? d0_r : bus.in_data[6:0];
                vel_s      = bus.in_data[6:0];
            end
        end else begin
            msg_done_s = 1'b0;
        end
        ch_match_s = (status_r[3:0] == CHAN_S);
        note_on_s  = msg_done_s && ch_match_s && (status_r[7:4] == 4'h9) && (vel_s != 7'd0);
        note_off_s = msg_done_s && ch_match_s &&
                     ((status_r[7:4] == 4'h8) || ((status_r[7:4] == 4'h9) && (vel_s == 7'd0)));
    end

`ifdef MIDI_GATE_RETRIGGER_EN
    assign retrig_s = note_on_s && gate;
`else
    assign retrig_s = 1'b0;
`endif

    // Next stack contents: index 0 is the oldest entry, index cnt_s-1 the top
    always_comb begin
        work_s  = stack_r;
        cnt_s   = int'(held);
        found_s = 1'b0;
        pos_s   = 32'sd0;
        top_s   = note;
        if (note_on_s || note_off_s) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (!found_s && (i < cnt_s) && (stack_r[i] == key_s)) begin
                    found_s = 1'b1;
                    pos_s   = i;
                end else begin
                    found_s = found_s;
                end
            end
            if (found_s) begin
                for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                    if (i >= pos_s) begin
                        work_s[i] = work_s[i+1];
                    end else begin
                        work_s[i] = work_s[i];
                    end
                end
                cnt_s = cnt_s - 32'sd1;
            end else begin
                cnt_s = cnt_s;
            end
            if (note_on_s) begin
                // A full stack sheds its oldest note to make room
                if (cnt_s == STACK_DEPTH) begin
                    for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                        work_s[i] = work_s[i+1];
                    end
                    cnt_s = cnt_s - 32'sd1;
                end else begin
                    cnt_s = cnt_s;
                end
                for (int i = 0; i < STACK_DEPTH; i++) begin
                    if (i == cnt_s) begin
                        work_s[i] = key_s;
                    end else begin
                        work_s[i] = work_s[i];
                    end
                end
                cnt_s = cnt_s + 32'sd1;
            end else begin
                cnt_s = cnt_s;
            end
        end else begin
            cnt_s = cnt_s;
        end
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (i == cnt_s - 32'sd1) begin
                top_s = work_s[i];
            end else begin
                top_s = top_s;
            end
        end
        held_next_s = HELD_W'(cnt_s);
    end

    // Running status and data-byte tracking; realtime bytes pass through untouched
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_r       <= 8'd0;
            status_valid_r <= 1'b0;
            have_d0_r      <= 1'b0;
            d0_r           <= 7'd0;
        end else if (bus.in_valid) begin
            if (bus.in_data >= 8'hF8) begin
                status_valid_r <= status_valid_r;
            end else if (bus.in_data >= 8'hF0) begin
                status_valid_r <= 1'b0;
                have_d0_r      <= 1'b0;
            end else if (bus.in_data[7]) begin
                status_r       <= bus.in_data;
                status_valid_r <= 1'b1;
                have_d0_r      <= 1'b0;
            end else if (status_valid_r) begin
                if (need_two_s && !have_d0_r) begin
                    d0_r      <= bus.in_data[6:0];
                    have_d0_r <= 1'b1;
                end else begin
                    have_d0_r <= 1'b0;
                end
            end else begin
                have_d0_r <= 1'b0;
            end
        end else begin
            status_valid_r <= status_valid_r;
        end
    end

    // Stack and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_r[i] <= 7'd0;
            end
            held     <= {HELD_W{1'b0}};
            gate     <= 1'b0;
            note     <= 7'd0;
            velocity <= 7'd0;
        end else begin
            stack_r <= work_s;
            held    <= held_next_s;
            gate    <= retrig_s ? 1'b0 : (held_next_s != {HELD_W{1'b0}});
            note    <= top_s;
            if (note_on_s) begin
                velocity <= vel_s;
            end else begin
                velocity <= velocity;
            end
        end
    end
endmodule

// File: tb/tb_midi_gate.sv
// Randomised scoreboard bench for midi_gate against a queue-based note-stack model.
module tb_midi_gate;
    localparam int CH    = 0;
    localparam int DEPTH = 4;
`ifdef MIDI_GATE_RETRIGGER_EN
    localparam bit RET = 1'b1;
`else
    localparam bit RET = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       gate;
    logic [6:0] note;
    logic [6:0] velocity;
    logic [2:0] held;

    midi_gate_if bus ();

    midi_gate #(.CHANNEL(CH), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .gate(gate), .note(note), .velocity(velocity), .held(held)
    );

    always #5 clk = ~clk;

    typedef struct {int g; int n; int v; int h;} exp_t;
    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Reference model state
    int rs;
    bit rs_ok;
    bit have_d0;
    int d0;
    int stk[$];
    int note_e;
    int vel_e;
    int gate_e;

    function automatic void check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void m_reset();
        rs = 0; rs_ok = 0; have_d0 = 0; d0 = 0;
        stk.delete();
        note_e = 0; vel_e = 0; gate_e = 0;
    endfunction

    function automatic void m_step(int b, bit v);
        bit pulse = 0;
        int len, k, vv;
        if (v) begin
            if (b >= 'hF8) begin
            end else if (b >= 'hF0) begin
                rs_ok = 0; have_d0 = 0;
            end else if (b >= 'h80) begin
                rs = b; rs_ok = 1; have_d0 = 0;
            end else if (rs_ok) begin
                len = (rs >= 'hC0 && rs <= 'hDF) ? 1 : 2;
                if (len == 2 && !have_d0) begin
                    d0 = b; have_d0 = 1;
                end else begin
                    have_d0 = 0;
                    k  = (len == 2) ? d0 : b;
                    vv = b;
                    if ((rs % 16) == CH && (rs / 16 == 9) && vv != 0) begin
                        pulse = RET && (gate_e != 0);
                        for (int i = 0; i < stk.size(); i++)
                            if (stk[i] == k) begin stk.delete(i); break; end
                        if (stk.size() == DEPTH) void'(stk.pop_front());
                        stk.push_back(k);
                        vel_e = vv; note_e = k;
                    end else if ((rs % 16) == CH && (rs / 16 == 8 || rs / 16 == 9)) begin
                        for (int i = 0; i < stk.size(); i++)
                            if (stk[i] == k) begin stk.delete(i); break; end
                        if (stk.size() != 0) note_e = stk[$];
                    end
                end
            end
        end
        gate_e = pulse ? 0 : (stk.size() != 0);
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.g = gate_e; e.n = note_e; e.v = vel_e; e.h = stk.size();
        exp_q.push_back(e);
    endfunction

    task automatic drive(input int b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b[7:0];
        m_step(b, 1'b1);
        push_exp();
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        m_step(0, 1'b0);
        push_exp();
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // g/n/v/h of -1 means "don't compare"
    task automatic chk4(input string tag, input int g, input int n, input int v, input int h);
        if (g >= 0) check({tag, "_gate"}, int'(gate), g);
        if (n >= 0) check({tag, "_note"}, int'(note), n);
        if (v >= 0) check({tag, "_vel"}, int'(velocity), v);
        if (h >= 0) check({tag, "_held"}, int'(held), h);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        m_reset();
        push_exp();
        #1;
        chk4("rst_async", 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        m_step(0, 1'b0);
        push_exp();
    endtask

    // Monitor: every cycle that has an expectation queued is compared
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("mon_gate", int'(gate), e.g);
                check("mon_note", int'(note), e.n);
                check("mon_vel", int'(velocity), e.v);
                check("mon_held", int'(held), e.h);
            end
        end
    end

    initial begin
        int r;
        reset_n      = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        m_reset();
        #2 reset_n = 1'b0;
        @(negedge clk);
        chk4("reset", 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        m_step(0, 1'b0);
        push_exp();

        // Basic on/off
        drive('h90); drive('h3C); drive('h64); settle();
        chk4("on1", 1, 'h3C, 'h64, 1);
        drive('h80); drive('h3C); drive('h00); settle();
        chk4("off1", 0, 'h3C, 'h64, 0);

        // Running status, Note Off by velocity 0
        drive('h90); drive('h3C); drive('h50); drive('h40); drive('h50); settle();
        chk4("rs_on", 1, 'h40, 'h50, 2);
        drive('h3C); drive('h00); settle();
        chk4("rs_off", 1, 'h40, 'h50, 1);
        drive('h40); drive('h00); settle();
        chk4("rs_clr", 0, 'h40, -1, 0);

        // Stack overflow and mid-stack removal
        drive('h90);
        drive(60); drive('h20); drive(62); drive('h20); drive(64); drive('h20);
        drive(65); drive('h20); drive(67); drive('h20); settle();
        chk4("full", 1, 67, 'h20, 4);
        drive('h80); drive(67); drive(0); settle();
        chk4("off_top", 1, 65, 'h20, 3);
        drive(60); drive(0); settle();
        chk4("off_dropped", 1, 65, 'h20, 3);
        drive(62); drive(0); drive(64); drive(0); drive(65); drive(0); settle();
        chk4("full_clr", 0, 65, -1, 0);

        // Realtime in the middle, other channel, system common
        drive('h90); drive('h3C); drive('hF8); drive('h64); settle();
        chk4("rt", 1, 'h3C, 'h64, 1);
        drive('h91); drive('h3C); drive('h70); settle();
        chk4("other_ch", 1, 'h3C, 'h64, 1);
        drive('hF0); drive('h3C); drive('h70); settle();
        chk4("syscommon", 1, 'h3C, 'h64, 1);
        drive('h80); drive('h3C); drive('h00); settle();
        chk4("rt_clr", 0, -1, -1, 0);

        // Overlapping Note On: retrigger pulse or legato
        drive('h90); drive('h3C); drive('h64); settle();
        drive('h40); drive('h64); settle();
        chk4("retrig", RET ? 0 : 1, 'h40, 'h64, 2);
        idle(); settle();
        chk4("retrig_after", 1, 'h40, 'h64, 2);
        drive('h80); drive('h3C); drive('h00); settle();
        chk4("expose", 1, 'h40, 'h64, 1);
        drive('h40); drive('h00); settle();

        // Reset mid-message
        drive('h90); drive('h3C);
        pulse_reset();
        drive('h64); settle();
        chk4("post_rst", 0, 0, 0, 0);

        // Randomised traffic
        for (int it = 0; it < 3000; it++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       idle();
            else if (r < 15) drive('h90);
            else if (r < 19) drive('h80);
            else if (r < 21) drive('h91 + $urandom_range(0, 1) * 'h10 - 'h10);
            else if (r < 23) drive('hC0 + $urandom_range(0, 1));
            else if (r < 24) drive('hE0);
            else if (r < 26) drive('hF0 + $urandom_range(0, 7));
            else if (r < 29) drive('hF8 + $urandom_range(0, 7));
            else if (r < 30) pulse_reset();
            else if ($urandom_range(0, 3) == 0) drive(0);
            else drive(60 + $urandom_range(0, 7));
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) check("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
